shift_reg_unit: RTL and testbench

SHIFT_REG_UNIT -- requirements
Module: shift_reg_unit

---
 rtl/shift_pkg.sv | 26 ++
 rtl/shift_reg_unit_if.sv | 27 ++
 rtl/shift_step.sv | 37 +++
 rtl/shift_reg_unit.sv | 84 ++++++++
 tb/tb_shift_reg_unit.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the shift register unit: operation codes,
// controller state encoding and a small decode helper.
package shift_pkg;

  // Operation codes as presented on the op port.
  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_PASS = 2'b11
  } op_t;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  // True when an accepted request needs no shifting at all and can
  // complete on the accepting edge.
  function automatic logic goes_direct(input op_t op, input logic shamt_is_zero);
    return (op == OP_PASS) || shamt_is_zero;
  endfunction

endpackage

// File: rtl/shift_reg_unit_if.sv
// Request/response bundle for the shift register unit. The requester
// drives start/op/data_in/shamt; the unit returns result/busy/done.
interface shift_reg_unit_if #(
  parameter int DATA_W = 32
) ();

  localparam int SHAMT_W = $clog2(DATA_W);

  logic                start;
  logic [1:0]          op;
  logic [DATA_W-1:0]   data_in;
  logic [SHAMT_W-1:0]  shamt;
  logic [DATA_W-1:0]   result;
  logic                busy;
  logic                done;

  modport master (
    output start, op, data_in, shamt,
    input  result, busy, done
  );

  modport slave (
    input  start, op, data_in, shamt,
    output result, busy, done
  );

endinterface

// File: rtl/shift_step.sv
// Combinational single-bit shift of a word according to the operation:
// SLL inserts 0 at the LSB, SRL inserts 0 at the MSB, SRA copies the MSB,
// PASS leaves the word unchanged.
module shift_step
  import shift_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  op_t               op,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_bit
      logic from_lower;  // bit moving up on a left shift
      logic from_upper;  // bit moving down on a right shift

      if (gi == 0) begin : g_lsb
        assign from_lower = 1'b0;
      end else begin : g_lower
        assign from_lower = din[gi-1];
      end

      if (gi == DATA_W - 1) begin : g_msb
        assign from_upper = (op == OP_SRA) ? din[DATA_W-1] : 1'b0;
      end else begin : g_upper
        assign from_upper = din[gi+1];
      end

      assign dout[gi] = (op == OP_SLL)  ? from_lower :
                        (op == OP_PASS) ? din[gi]    :
                                          from_upper;
    end
  endgenerate

endmodule

// File: rtl/shift_reg_unit.sv
// Iterative shifter: latches an operand on an accepted start, then shifts
// it one bit per cycle until the requested amount has been applied and
// pulses done for one cycle. All outputs come straight from registers.
module shift_reg_unit
  import shift_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  shift_reg_unit_if.slave  bus
);

  localparam int SHAMT_W = $clog2(DATA_W);

  state_t              state_reg, state_next;
  logic [DATA_W-1:0]   result_reg, result_next;
  logic [SHAMT_W-1:0]  count_reg, count_next;
  op_t                 op_reg, op_next;
  logic                busy_reg, done_reg;
  logic [DATA_W-1:0]   step_out;

  // One-bit shift of the working value by the latched operation.
  shift_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .op   (op_reg),
    .din  (result_reg),
    .dout (step_out)
  );

  // Next-state and datapath update; start is only honoured outside SHIFT.
  always_comb begin
    state_next  = state_reg;
    result_next = result_reg;
    count_next  = count_reg;
    op_next     = op_reg;
    unique case (state_reg)
      ST_IDLE, ST_DONE: begin
        state_next = ST_IDLE;
        if (bus.start) begin
          result_next = bus.data_in;
          op_next     = op_t'(bus.op);
          count_next  = bus.shamt;
          state_next  = goes_direct(op_t'(bus.op), bus.shamt == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        result_next = step_out;
        count_next  = count_reg - SHAMT_W'(1);
        if (count_reg == SHAMT_W'(1)) begin
          state_next = ST_DONE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, datapath and status registers; reset aborts any operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      result_reg <= '0;
      count_reg  <= '0;
      op_reg     <= OP_SLL;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      result_reg <= result_next;
      count_reg  <= count_next;
      op_reg     <= op_next;
      busy_reg   <= (state_next == ST_SHIFT);
      done_reg   <= (state_next == ST_DONE);
    end
  end

  assign bus.result = result_reg;
  assign bus.busy   = busy_reg;
  assign bus.done   = done_reg;

endmodule

// File: tb/tb_shift_reg_unit.sv
// Randomized self-checking bench for shift_reg_unit. The reference model
// tracks how many bit positions have been applied so far and computes the
// expected word in closed form with the language's shift operators.
module tb_shift_reg_unit;

  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic reset;

  shift_reg_unit_if #(.DATA_W(DATA_W)) bus ();

  shift_reg_unit #(.DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  int          m_remain;   // shift cycles still to run, 0 when not shifting
  logic [31:0] m_data;
  logic [1:0]  m_op;
  int          m_shamt;
  logic [31:0] m_result;
  logic        m_busy;
  logic        m_done;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Word after k of the requested bit positions have been applied.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [1:0] op, input int k);
    logic signed [31:0] sd;
    sd = d;
    case (op)
      2'b00:   return d << k;
      2'b01:   return d >> k;
      2'b10:   return sd >>> k;
      default: return d;
    endcase
  endfunction

  function automatic void model_reset();
    m_remain = 0;
    m_data   = '0;
    m_op     = 2'b00;
    m_shamt  = 0;
    m_result = '0;
    m_busy   = 1'b0;
    m_done   = 1'b0;
  endfunction

  // Model one rising edge with the inputs that were presented.
  function automatic void model_edge(input logic st, input logic [1:0] op,
                                     input logic [31:0] d, input logic [4:0] s);
    if (m_remain > 0) begin
      m_remain--;
      m_result = ref_shift(m_data, m_op, m_shamt - m_remain);
      m_busy   = (m_remain > 0);
      m_done   = (m_remain == 0);
    end else if (st) begin
      m_data  = d;
      m_op    = op;
      m_shamt = int'(s);
      $display("txn op=%0d data=%h shamt=%0d final=%h", op, d, s, ref_shift(d, op, int'(s)));
      if (s == 5'd0 || op == 2'b11) begin
        m_result = d;
        m_busy   = 1'b0;
        m_done   = 1'b1;
      end else begin
        m_remain = int'(s);
        m_result = d;
        m_busy   = 1'b1;
        m_done   = 1'b0;
      end
    end else begin
      m_busy = 1'b0;
      m_done = 1'b0;
    end
  endfunction

  task automatic check_outputs(input string tag);
    check_val({tag, ".busy"},   32'(bus.busy),   32'(m_busy));
    check_val({tag, ".done"},   32'(bus.done),   32'(m_done));
    check_val({tag, ".result"}, bus.result,      m_result);
  endtask

  // Called at a falling edge: present inputs, clock once, check outputs.
  task automatic cycle(input string tag, input logic st, input logic [1:0] op,
                       input logic [31:0] d, input logic [4:0] s);
    bus.start   = st;
    bus.op      = op;
    bus.data_in = d;
    bus.shamt   = s;
    @(posedge clk);
    model_edge(st, op, d, s);
    @(negedge clk);
    check_outputs(tag);
  endtask

  // Idle cycles with don't-care operand inputs randomized.
  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      cycle(tag, 1'b0, 2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)));
    end
  endtask

  // Called at a falling edge: reset takes effect at once, released one cycle later.
  task automatic pulse_reset(input string tag);
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b0;
    bus.start   = 1'b0;
    bus.op      = 2'b00;
    bus.data_in = '0;
    bus.shamt   = '0;
    model_reset();
    #1 reset = 1'b1;
    #2;
    check_outputs("reset");
    @(negedge clk);
    reset = 1'b0;

    // SLL 1 by 4, accepted on the first edge after reset.
    cycle("sll4", 1'b1, 2'b00, 32'h0000_0001, 5'd4);
    idle("sll4", 5);
    check_val("sll4.final", bus.result, 32'h0000_0010);

    // SRA of a negative operand by the maximum amount.
    cycle("sra31", 1'b1, 2'b10, 32'h8000_0000, 5'd31);
    idle("sra31", 33);
    check_val("sra31.final", bus.result, 32'hFFFF_FFFF);

    // Zero shift completes immediately.
    cycle("srl0", 1'b1, 2'b01, 32'h8000_0000, 5'd0);
    idle("srl0", 2);

    // Start during SHIFT is ignored.
    cycle("srl8", 1'b1, 2'b01, 32'hF000_0000, 5'd8);
    idle("srl8", 1);
    cycle("srl8.ign", 1'b1, 2'b00, 32'h0000_0001, 5'd1);
    idle("srl8", 10);
    check_val("srl8.final", bus.result, 32'h00F0_0000);

    // Reset mid-shift aborts with no done, then PASS.
    cycle("abort", 1'b1, 2'b00, 32'h0000_FFFF, 5'd16);
    idle("abort", 4);
    pulse_reset("abort.rst");
    idle("abort.after", 3);
    cycle("pass", 1'b1, 2'b11, 32'h0000_ABCD, 5'd7);
    idle("pass", 2);
    check_val("pass.final", bus.result, 32'h0000_ABCD);

    // Back-to-back: new start presented in the DONE cycle.
    cycle("b2b.first", 1'b1, 2'b01, 32'h1234_5678, 5'd2);
    for (int i = 0; i < 40 && !m_done; i++) begin
      idle("b2b.wait", 1);
    end
    check_val("b2b.in_done", 32'(bus.done), 32'd1);
    cycle("b2b.second", 1'b1, 2'b10, 32'hFFFF_FF00, 5'd4);
    idle("b2b", 6);
    check_val("b2b.final", bus.result, 32'hFFFF_FFF0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      logic [4:0] s;
      int sel;
      sel = int'($urandom_range(0, 9));
      s = (sel == 0) ? 5'd0 : (sel == 1) ? 5'd31 : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 199) == 0) begin
        pulse_reset("rand.rst");
      end else begin
        cycle("rand", ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)), $urandom, s);
      end
    end
    idle("drain", 34);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
    $finish;
  end

endmodule
